// File: rtl/wb_exc_commit.sv
// wb_exc_commit
//   Write-back-stage exception / CP0-access commit unit. Produces the
//   WB-to-CP0 register bus, raises the pipeline flush, and holds a redirect
//   request toward fetch until fetch accepts it.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   ws_valid                    WB holds a valid instruction (one cycle each)
//   ws_ex/ws_excode/ws_badvaddr exception carried from an earlier stage
//   ws_bd, ws_pc                delay-slot flag and instruction PC
//   ws_mtc0/ws_c0_addr/ws_c0_wdata  MTC0 write request
//   ws_eret                     instruction is ERET
//   has_int                     interrupt pending (from CP0 register file)
//   cp0_epc                     current EPC (from CP0 register file)
//   redirect_ready              fetch accepts the redirect this cycle
//   wb_to_cp0_register_bus      {ex, excode, badvaddr, bd, pc, mtc0_we,
//                                waddr, wdata, eret_flush}
//   flush                       combinational kill of younger instructions
//   redirect_valid/redirect_pc  registered redirect request to fetch
//   wb_busy                     redirect outstanding; WB must not advance
module wb_exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CR_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ws_valid,
  input  logic                 ws_ex,
  input  logic [4:0]           ws_excode,
  input  logic [31:0]          ws_badvaddr,
  input  logic                 ws_bd,
  input  logic [31:0]          ws_pc,
  input  logic                 ws_mtc0,
  input  logic [CR_W-1:0]      ws_c0_addr,
  input  logic [31:0]          ws_c0_wdata,
  input  logic                 ws_eret,
  input  logic                 has_int,
  input  logic [31:0]          cp0_epc,
  input  logic                 redirect_ready,
  output logic [104+CR_W:0]    wb_to_cp0_register_bus,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 wb_busy
);

  typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

  state_t      state_reg;
  logic        int_q_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;

  logic            acc;
  logic            take_int;
  logic            take_ex;
  logic            ex;
  logic            eret_flush;
  logic            mtc0_we;
  logic [4:0]      excode;
  logic [31:0]     badvaddr;
  logic            bd;
  logic [31:0]     pc;
  logic [CR_W-1:0] waddr;
  logic [31:0]     wdata;

  // Commit decision. Data fields are zeroed unless the matching control bit
  // is set, so the bus is fully deterministic on idle / ignored cycles.
  always_comb begin
    acc        = ws_valid && (state_reg == IDLE);
    take_int   = acc && int_q_reg;
    take_ex    = acc && !int_q_reg && ws_ex;
    ex         = take_int || take_ex;
    eret_flush = acc && !ex && ws_eret;
    mtc0_we    = acc && !ex && !ws_eret && ws_mtc0;

    excode     = take_ex ? ws_excode   : 5'd0;  // interrupt code is 0
    badvaddr   = ex      ? ws_badvaddr : 32'd0;
    bd         = ex      ? ws_bd       : 1'b0;
    pc         = ex      ? ws_pc       : 32'd0;
    waddr      = mtc0_we ? ws_c0_addr  : '0;
    wdata      = mtc0_we ? ws_c0_wdata : 32'd0;

    flush      = ex || eret_flush;
  end

  assign wb_to_cp0_register_bus = {ex, excode, badvaddr, bd, pc,
                                   mtc0_we, waddr, wdata, eret_flush};
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign wb_busy        = (state_reg == REDIRECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      int_q_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= 32'd0;
    end else begin
      // A committed interrupt consumes the sampled request so the same
      // pending level cannot fire twice on back-to-back edges.
      int_q_reg <= take_int ? 1'b0 : has_int;

      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg          <= REDIRECT;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= ex ? EXC_VECTOR : cp0_epc;
          end
        end
        REDIRECT: begin
          // Fetch may stall on an I-cache miss; hold target until taken.
          if (redirect_ready) begin
            state_reg          <= IDLE;
            redirect_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg          <= IDLE;
          redirect_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed testbench for wb_exc_commit: each task drives one scenario and
// compares outputs against hand-computed expected values.
module tb_wb_exc_commit;

  logic          clk;
  logic          reset;
  logic          ws_valid;
  logic          ws_ex;
  logic [4:0]    ws_excode;
  logic [31:0]   ws_badvaddr;
  logic          ws_bd;
  logic [31:0]   ws_pc;
  logic          ws_mtc0;
  logic [4:0]    ws_c0_addr;
  logic [31:0]   ws_c0_wdata;
  logic          ws_eret;
  logic          has_int;
  logic [31:0]   cp0_epc;
  logic          redirect_ready;
  logic [109:0]  bus;
  logic          flush;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          wb_busy;

  int total = 0;
  int bad   = 0;

  logic [109:0] exp_bus;

  wb_exc_commit dut (
    .clk                    (clk),
    .reset                  (reset),
    .ws_valid               (ws_valid),
    .ws_ex                  (ws_ex),
    .ws_excode              (ws_excode),
    .ws_badvaddr            (ws_badvaddr),
    .ws_bd                  (ws_bd),
    .ws_pc                  (ws_pc),
    .ws_mtc0                (ws_mtc0),
    .ws_c0_addr             (ws_c0_addr),
    .ws_c0_wdata            (ws_c0_wdata),
    .ws_eret                (ws_eret),
    .has_int                (has_int),
    .cp0_epc                (cp0_epc),
    .redirect_ready         (redirect_ready),
    .wb_to_cp0_register_bus (bus),
    .flush                  (flush),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .wb_busy                (wb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ws;
    ws_valid    = 1'b0;
    ws_ex       = 1'b0;
    ws_excode   = 5'd0;
    ws_badvaddr = 32'd0;
    ws_bd       = 1'b0;
    ws_pc       = 32'd0;
    ws_mtc0     = 1'b0;
    ws_c0_addr  = 5'd0;
    ws_c0_wdata = 32'd0;
    ws_eret     = 1'b0;
  endtask

  task automatic test_reset;
    clear_ws();
    has_int = 1'b0; cp0_epc = 32'd0; redirect_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus !== 110'd0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
        redirect_pc !== 32'd0 || wb_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: bus=%h flush=%b rv=%b rpc=%h busy=%b, want all 0",
               bus, flush, redirect_valid, redirect_pc, wb_busy);
    end
    $display("reset: bus=%h rv=%b rpc=%h", bus, redirect_valid, redirect_pc);
  endtask

  task automatic test_mtc0;
    tick();
    ws_valid = 1; ws_mtc0 = 1; ws_c0_addr = 5'd11; ws_c0_wdata = 32'h0000_1234;
    #1;
    exp_bus = {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd11, 32'h0000_1234, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b0) begin
      bad++;
      $display("FAIL mtc0_1: bus=%h flush=%b want bus=%h flush=0", bus, flush, exp_bus);
    end
    $display("mtc0_1: bus=%h flush=%b", bus, flush);
    tick();
    ws_c0_addr = 5'd12; ws_c0_wdata = 32'h0000_5678;
    #1;
    exp_bus = {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd12, 32'h0000_5678, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b0 || wb_busy !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL mtc0_2: bus=%h flush=%b busy=%b rv=%b want bus=%h 0 0 0",
               bus, flush, wb_busy, redirect_valid, exp_bus);
    end
    $display("mtc0_2: bus=%h busy=%b", bus, wb_busy);
    tick();
    clear_ws();
    ws_valid = 1; ws_pc = 32'h1111_2222;
    #1;
    total++;
    if (bus !== 110'd0 || flush !== 1'b0 || wb_busy !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL plain: bus=%h flush=%b busy=%b rv=%b want all 0",
               bus, flush, wb_busy, redirect_valid);
    end
    $display("plain: bus=%h flush=%b", bus, flush);
    tick();
    clear_ws();
  endtask

  task automatic test_exception;
    redirect_ready = 0;
    ws_valid = 1; ws_ex = 1; ws_excode = 5'd4; ws_badvaddr = 32'h0000_0003;
    ws_pc = 32'hBFC0_0100; ws_bd = 1;
    #1;
    exp_bus = {1'b1, 5'd4, 32'h0000_0003, 1'b1, 32'hBFC0_0100, 1'b0, 5'd0, 32'd0, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b1) begin
      bad++;
      $display("FAIL exc_bus: bus=%h flush=%b want bus=%h flush=1", bus, flush, exp_bus);
    end
    $display("exc: bus=%h flush=%b", bus, flush);
    tick();
    clear_ws();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380 || wb_busy !== 1'b1 ||
          flush !== 1'b0) begin
        bad++;
        $display("FAIL exc_hold%0d: rv=%b rpc=%h busy=%b flush=%b want 1 bfc00380 1 0",
                 i, redirect_valid, redirect_pc, wb_busy, flush);
      end
      $display("exc_hold%0d: rv=%b rpc=%h busy=%b", i, redirect_valid, redirect_pc, wb_busy);
      tick();
    end
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    #1;
    total++;
    if (redirect_valid !== 1'b0 || wb_busy !== 1'b0) begin
      bad++;
      $display("FAIL exc_release: rv=%b busy=%b want 0 0", redirect_valid, wb_busy);
    end
    $display("exc_release: rv=%b busy=%b", redirect_valid, wb_busy);
  endtask

  task automatic test_eret;
    cp0_epc = 32'hBFC0_1000;
    ws_valid = 1; ws_eret = 1;
    #1;
    exp_bus = {109'd0, 1'b1};
    total++;
    if (bus !== exp_bus || flush !== 1'b1) begin
      bad++;
      $display("FAIL eret_bus: bus=%h flush=%b want bus=%h flush=1", bus, flush, exp_bus);
    end
    $display("eret: bus=%h flush=%b", bus, flush);
    tick();
    clear_ws();
    cp0_epc = 32'hDEAD_BEEF;  // target must be the value sampled at flush
    redirect_ready = 1;
    #1;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_1000 || wb_busy !== 1'b1) begin
      bad++;
      $display("FAIL eret_redirect: rv=%b rpc=%h busy=%b want 1 bfc01000 1",
               redirect_valid, redirect_pc, wb_busy);
    end
    $display("eret_redirect: rv=%b rpc=%h", redirect_valid, redirect_pc);
    tick();
    redirect_ready = 0;
    #1;
    total++;
    if (redirect_valid !== 1'b0 || wb_busy !== 1'b0) begin
      bad++;
      $display("FAIL eret_release: rv=%b busy=%b want 0 0", redirect_valid, wb_busy);
    end
    $display("eret_release: rv=%b busy=%b", redirect_valid, wb_busy);
  endtask

  task automatic test_interrupt;
    // has_int becomes eligible only one cycle later.
    has_int = 1;
    ws_valid = 1; ws_mtc0 = 1; ws_c0_addr = 5'd9; ws_c0_wdata = 32'h0000_00AA;
    #1;
    exp_bus = {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd9, 32'h0000_00AA, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b0) begin
      bad++;
      $display("FAIL int_latency: bus=%h flush=%b want bus=%h flush=0", bus, flush, exp_bus);
    end
    $display("int_latency: bus=%h", bus);
    tick();
    ws_mtc0 = 1; ws_eret = 1; ws_badvaddr = 32'h0000_0044; ws_pc = 32'hBFC0_0200;
    #1;
    exp_bus = {1'b1, 5'd0, 32'h0000_0044, 1'b0, 32'hBFC0_0200, 1'b0, 5'd0, 32'd0, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b1) begin
      bad++;
      $display("FAIL int_priority: bus=%h flush=%b want bus=%h flush=1", bus, flush, exp_bus);
    end
    $display("int_priority: bus=%h flush=%b", bus, flush);
    tick();
    has_int = 0;
    clear_ws();
    redirect_ready = 1;
    #1;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380) begin
      bad++;
      $display("FAIL int_redirect: rv=%b rpc=%h want 1 bfc00380", redirect_valid, redirect_pc);
    end
    $display("int_redirect: rv=%b rpc=%h", redirect_valid, redirect_pc);
    tick();
    redirect_ready = 0;
    ws_valid = 1; ws_mtc0 = 1; ws_c0_addr = 5'd3; ws_c0_wdata = 32'h0000_0009;
    #1;
    exp_bus = {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd3, 32'h0000_0009, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b0) begin
      bad++;
      $display("FAIL int_cleared: bus=%h flush=%b want bus=%h flush=0", bus, flush, exp_bus);
    end
    $display("int_cleared: bus=%h", bus);
    tick();
    clear_ws();
  endtask

  task automatic test_ignore_redirect;
    ws_valid = 1; ws_ex = 1; ws_excode = 5'd10; ws_pc = 32'h0000_0040;
    tick();
    ws_mtc0 = 1; ws_c0_addr = 5'd7; ws_c0_wdata = 32'h1234_5678; ws_excode = 5'd5;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus !== 110'd0 || flush !== 1'b0 || wb_busy !== 1'b1) begin
        bad++;
        $display("FAIL ignore%0d: bus=%h flush=%b busy=%b want 0 0 1", i, bus, flush, wb_busy);
      end
      $display("ignore%0d: bus=%h flush=%b busy=%b", i, bus, flush, wb_busy);
      tick();
    end
    clear_ws();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  task automatic test_reset_mid;
    ws_valid = 1; ws_eret = 1; cp0_epc = 32'h8000_0000;
    tick();
    clear_ws();
    has_int = 1;
    #1;
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rmid_enter: rv=%b rpc=%h want 1 80000000", redirect_valid, redirect_pc);
    end
    $display("rmid_enter: rv=%b rpc=%h", redirect_valid, redirect_pc);
    tick();
    reset = 1;
    tick();
    reset = 0; has_int = 0;
    #1;
    total++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || wb_busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_reset: rv=%b rpc=%h busy=%b want 0 0 0",
               redirect_valid, redirect_pc, wb_busy);
    end
    $display("rmid_reset: rv=%b rpc=%h busy=%b", redirect_valid, redirect_pc, wb_busy);
    ws_valid = 1; ws_mtc0 = 1; ws_c0_addr = 5'd1; ws_c0_wdata = 32'h0000_0001;
    #1;
    exp_bus = {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd1, 32'h0000_0001, 1'b0};
    total++;
    if (bus !== exp_bus || flush !== 1'b0) begin
      bad++;
      $display("FAIL rmid_intq: bus=%h flush=%b want bus=%h flush=0", bus, flush, exp_bus);
    end
    $display("rmid_intq: bus=%h", bus);
    tick();
    clear_ws();
  endtask

  initial begin
    test_reset();
    test_mtc0();
    test_exception();
    test_eret();
    test_interrupt();
    test_ignore_redirect();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
